// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, strobe levels and default address width
// for the fetch sequencer. Rev 1.0
`default_nettype none

package fetch_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 5;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    MEM    = 3'd2,
    DATA   = 3'd3,
    LOAD   = 3'd4,
    HOLD   = 3'd5,
    UPDATE = 3'd6
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_wait_counter.sv
// fetch_wait_counter: program-memory wait down-counter; done flags the last
// wait cycle. Rev 1.0
`default_nettype none

module fetch_wait_counter #(
  parameter int unsigned WAIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic done_o
);

  localparam logic [2:0] LOAD_VAL = 3'(WAIT);

  logic [2:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 3'd0;
    end else if (load_i) begin
      count_q <= LOAD_VAL;
    end else if (count_q != 3'd0) begin
      count_q <= count_q - 3'd1;
    end
  end

  assign done_o = (count_q <= 3'd1);

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: strobes the PC/MAR/PM/MDR/IR fetch datapath in order, owns
// the PC and hands the IR to decode with a valid/ack handshake. Rev 1.0
`default_nettype none

module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              ir_ack,
  output logic              PC_rd_wr,
  output logic              MAR_rd_wr,
  output logic              PM_rd_wr,
  output logic              MDR_rd_wr,
  output logic              IR_rd_wr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              fetch_valid,
  output logic              busy,
  output logic [15:0]       fetch_count
);

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              count_inc;
  logic              wait_done;
  logic              pc_rd_wr_q, mar_rd_wr_q, mdr_rd_wr_q, ir_rd_wr_q;
  logic              fetch_valid_q, busy_q;
  logic [15:0]       fetch_count_q;

  fetch_wait_counter #(
    .WAIT (MEM_WAIT)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == ADDR),
    .done_o (wait_done)
  );

  // A branch pre-empts every state; the PC is committed on entry to UPDATE so
  // pc_addr already shows the new value during the PC write strobe.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_inc = 1'b0;
    if (branch_valid) begin
      state_d = UPDATE;
      pc_d    = branch_target;
    end else begin
      unique case (state_q)
        IDLE:    if (start && !halt) state_d = ADDR;
        ADDR:    state_d = (MEM_WAIT == 0) ? DATA : MEM;
        MEM:     if (wait_done) state_d = DATA;
        DATA:    state_d = LOAD;
        LOAD:    state_d = HOLD;
        HOLD: begin
          if (ir_ack) begin
            count_inc = 1'b1;
            pc_d      = pc_q + ADDR_W'(1);
            state_d   = UPDATE;
          end
        end
        UPDATE:  state_d = (halt || !start) ? IDLE : ADDR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= PC_INIT;
      pc_rd_wr_q    <= RD;
      mar_rd_wr_q   <= RD;
      mdr_rd_wr_q   <= RD;
      ir_rd_wr_q    <= RD;
      fetch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      fetch_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mar_rd_wr_q   <= (state_d == ADDR)   ? WR : RD;
      mdr_rd_wr_q   <= (state_d == DATA)   ? WR : RD;
      ir_rd_wr_q    <= (state_d == LOAD)   ? WR : RD;
      pc_rd_wr_q    <= (state_d == UPDATE) ? WR : RD;
      fetch_valid_q <= (state_d == HOLD);
      busy_q        <= (state_d != IDLE);
      if (count_inc) fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign PC_rd_wr    = pc_rd_wr_q;
  assign MAR_rd_wr   = mar_rd_wr_q;
  assign PM_rd_wr    = RD;
  assign MDR_rd_wr   = mdr_rd_wr_q;
  assign IR_rd_wr    = ir_rd_wr_q;
  assign pc_addr     = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign busy        = busy_q;
  assign fetch_count = fetch_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed-vector bench for fetch_sequencer (ADDR_W=5,
// MEM_WAIT=1, RESET_PC=0). Rev 1.0
`default_nettype none

module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, halt, branch_valid, ir_ack;
  logic [4:0] branch_target;
  logic       PC_rd_wr, MAR_rd_wr, PM_rd_wr, MDR_rd_wr, IR_rd_wr;
  logic [4:0] pc_addr;
  logic       fetch_valid, busy;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(
    .ADDR_W   (5),
    .MEM_WAIT (1),
    .RESET_PC (0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .halt          (halt),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .ir_ack        (ir_ack),
    .PC_rd_wr      (PC_rd_wr),
    .MAR_rd_wr     (MAR_rd_wr),
    .PM_rd_wr      (PM_rd_wr),
    .MDR_rd_wr     (MDR_rd_wr),
    .IR_rd_wr      (IR_rd_wr),
    .pc_addr       (pc_addr),
    .fetch_valid   (fetch_valid),
    .busy          (busy),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // {MAR, MDR, IR, PC, fetch_valid}
  function automatic logic [4:0] strobes();
    return {MAR_rd_wr, MDR_rd_wr, IR_rd_wr, PC_rd_wr, fetch_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; halt = 1'b0;
    branch_valid = 1'b0; branch_target = 5'd0; ir_ack = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({PC_rd_wr, MAR_rd_wr, PM_rd_wr, MDR_rd_wr, IR_rd_wr, fetch_valid, busy} !== 7'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0000000",
        {PC_rd_wr, MAR_rd_wr, PM_rd_wr, MDR_rd_wr, IR_rd_wr, fetch_valid, busy});
    end
    n_checks++;
    if (pc_addr !== 5'd0 || fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_pc_count: got pc=%0d cnt=%0d want pc=0 cnt=0", pc_addr, fetch_count);
    end
  endtask

  task automatic test_normal_fetch();
    logic [4:0] exp_tbl [6];
    exp_tbl[0] = 5'b10000; exp_tbl[1] = 5'b00000; exp_tbl[2] = 5'b01000;
    exp_tbl[3] = 5'b00100; exp_tbl[4] = 5'b00001; exp_tbl[5] = 5'b00010;
    apply_reset();
    start = 1'b1; ir_ack = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      n_checks++;
      if (strobes() !== exp_tbl[(c-1)%6] || busy !== 1'b1 || PM_rd_wr !== 1'b0) begin
        n_fail++; $display("FAIL normal_strobes c=%0d: got %b busy=%b pm=%b want %b busy=1 pm=0",
          c, strobes(), busy, PM_rd_wr, exp_tbl[(c-1)%6]);
      end
      n_checks++;
      if (pc_addr !== 5'(c/6) || fetch_count !== 16'(c/6)) begin
        n_fail++; $display("FAIL normal_pc c=%0d: got pc=%0d cnt=%0d want %0d/%0d",
          c, pc_addr, fetch_count, c/6, c/6);
      end
    end
    start = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || pc_addr !== 5'd2) begin
      n_fail++; $display("FAIL normal_idle: got busy=%b pc=%0d want busy=0 pc=2", busy, pc_addr);
    end
  endtask

  task automatic test_ack_stall();
    apply_reset();
    start = 1'b1; ir_ack = 1'b0;
    repeat (5) tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (strobes() !== 5'b00001 || pc_addr !== 5'd0 || fetch_count !== 16'd0) begin
        n_fail++; $display("FAIL stall_hold c=%0d: got %b pc=%0d cnt=%0d want 00001 pc=0 cnt=0",
          c, strobes(), pc_addr, fetch_count);
      end
    end
    ir_ack = 1'b1;
    tick();
    n_checks++;
    if (strobes() !== 5'b00010 || pc_addr !== 5'd1 || fetch_count !== 16'd1) begin
      n_fail++; $display("FAIL stall_release: got %b pc=%0d cnt=%0d want 00010 pc=1 cnt=1",
        strobes(), pc_addr, fetch_count);
    end
    start = 1'b0; ir_ack = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL stall_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_branch_mem();
    apply_reset();
    start = 1'b1; ir_ack = 1'b1;
    repeat (2) tick();
    branch_valid = 1'b1; branch_target = 5'd5;
    tick();
    branch_valid = 1'b0; branch_target = 5'd0;
    n_checks++;
    if (strobes() !== 5'b00010 || pc_addr !== 5'd5 || fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL branch_update: got %b pc=%0d cnt=%0d want 00010 pc=5 cnt=0",
        strobes(), pc_addr, fetch_count);
    end
    tick();
    n_checks++;
    if (strobes() !== 5'b10000 || pc_addr !== 5'd5) begin
      n_fail++; $display("FAIL branch_refetch: got %b pc=%0d want 10000 pc=5", strobes(), pc_addr);
    end
    repeat (4) tick();
    n_checks++;
    if (fetch_valid !== 1'b1 || pc_addr !== 5'd5) begin
      n_fail++; $display("FAIL branch_hold: got fv=%b pc=%0d want fv=1 pc=5", fetch_valid, pc_addr);
    end
    tick();
    n_checks++;
    if (strobes() !== 5'b00010 || pc_addr !== 5'd6 || fetch_count !== 16'd1) begin
      n_fail++; $display("FAIL branch_next: got %b pc=%0d cnt=%0d want 00010 pc=6 cnt=1",
        strobes(), pc_addr, fetch_count);
    end
    start = 1'b0; ir_ack = 1'b0;
    tick();
  endtask

  task automatic test_wrap_and_collision();
    apply_reset();
    branch_valid = 1'b1; branch_target = 5'd31;
    tick();
    branch_valid = 1'b0;
    n_checks++;
    if (strobes() !== 5'b00010 || pc_addr !== 5'd31 || busy !== 1'b1) begin
      n_fail++; $display("FAIL idle_branch: got %b pc=%0d busy=%b want 00010 pc=31 busy=1",
        strobes(), pc_addr, busy);
    end
    start = 1'b1; ir_ack = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (strobes() !== 5'b00010 || pc_addr !== 5'd0 || fetch_count !== 16'd1) begin
      n_fail++; $display("FAIL wrap: got %b pc=%0d cnt=%0d want 00010 pc=0 cnt=1",
        strobes(), pc_addr, fetch_count);
    end
    repeat (5) tick();
    n_checks++;
    if (fetch_valid !== 1'b1) begin
      n_fail++; $display("FAIL collide_hold: got fv=%b want 1", fetch_valid);
    end
    branch_valid = 1'b1; branch_target = 5'd9;
    tick();
    branch_valid = 1'b0;
    n_checks++;
    if (strobes() !== 5'b00010 || pc_addr !== 5'd9 || fetch_count !== 16'd1) begin
      n_fail++; $display("FAIL collide_branch: got %b pc=%0d cnt=%0d want 00010 pc=9 cnt=1",
        strobes(), pc_addr, fetch_count);
    end
    start = 1'b0; ir_ack = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || pc_addr !== 5'd9) begin
      n_fail++; $display("FAIL collide_idle: got busy=%b pc=%0d want busy=0 pc=9", busy, pc_addr);
    end
  endtask

  task automatic test_halt_and_reset();
    apply_reset();
    start = 1'b1; ir_ack = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (strobes() !== 5'b01000) begin
      n_fail++; $display("FAIL halt_data: got %b want 01000", strobes());
    end
    halt = 1'b1;
    tick();
    n_checks++;
    if (strobes() !== 5'b00100) begin
      n_fail++; $display("FAIL halt_load: got %b want 00100", strobes());
    end
    repeat (2) tick();
    n_checks++;
    if (strobes() !== 5'b00001 || busy !== 1'b1) begin
      n_fail++; $display("FAIL halt_hold: got %b busy=%b want 00001 busy=1", strobes(), busy);
    end
    ir_ack = 1'b1;
    tick();
    ir_ack = 1'b0;
    n_checks++;
    if (strobes() !== 5'b00010 || pc_addr !== 5'd1) begin
      n_fail++; $display("FAIL halt_update: got %b pc=%0d want 00010 pc=1", strobes(), pc_addr);
    end
    repeat (2) tick();
    n_checks++;
    if (busy !== 1'b0 || strobes() !== 5'b00000) begin
      n_fail++; $display("FAIL halt_idle: got busy=%b %b want busy=0 00000", busy, strobes());
    end
    halt = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; start = 1'b0;
    n_checks++;
    if ({strobes(), PM_rd_wr, busy} !== 7'd0 || pc_addr !== 5'd0 || fetch_count !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset: got %b busy=%b pc=%0d cnt=%0d want all 0",
        strobes(), busy, pc_addr, fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_normal_fetch();
    test_ack_stall();
    test_branch_mem();
    test_wrap_and_collision();
    test_halt_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
